rat_ckpt: RTL and testbench

RAT_CKPT -- requirements
Module: rat_ckpt

---
 rtl/rat_ckpt.sv | 190 +++++++++++++++++++
 tb/tb_rat_ckpt.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_ckpt.sv
// rat_ckpt -- register alias table with checkpoint / restore / flush.
//
// Holds a speculative map (logical -> physical register tag), an
// architectural map updated by commits, and a circular FIFO of NCKPT
// snapshots of the speculative map.
//
// Ports
//   clock           sole clock
//   reset           asynchronous active-high reset
//   rd_lreg         per port {lrd,lrs2,lrs1} lookup addresses
//   rd_preg         registered lookup results, same packing
//   wr_valid/wr_lreg/wr_preg   speculative rename writes (port 0 oldest)
//   cm_valid/cm_lreg/cm_preg   commit writes to the architectural map
//   ck_alloc_valid/ck_alloc_ready/ck_alloc_id   checkpoint allocation
//   ck_rel_valid    free the oldest checkpoint
//   ck_rst_valid/ck_rst_id     restore speculative map from a checkpoint
//   flush_valid     copy architectural map into speculative map
//   ck_count        number of live checkpoints
//
// Optional feature macro: RAT_CKPT_BYPASS_EN
//   defined   : lookups of port k see same-cycle writes from ports < k
//   undefined : lookups see only the pre-write speculative map
module rat_ckpt #(
  parameter int NUM_LREG = 32,
  parameter int PREG_W   = 6,
  parameter int NPORT    = 2,
  parameter int NCKPT    = 4,
  parameter int LREG_W   = $clog2(NUM_LREG),
  parameter int CK_W     = $clog2(NCKPT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3*NPORT*LREG_W-1:0]   rd_lreg,
  output logic [3*NPORT*PREG_W-1:0]   rd_preg,
  input  logic [NPORT-1:0]            wr_valid,
  input  logic [NPORT*LREG_W-1:0]     wr_lreg,
  input  logic [NPORT*PREG_W-1:0]     wr_preg,
  input  logic [NPORT-1:0]            cm_valid,
  input  logic [NPORT*LREG_W-1:0]     cm_lreg,
  input  logic [NPORT*PREG_W-1:0]     cm_preg,
  input  logic                        ck_alloc_valid,
  output logic                        ck_alloc_ready,
  output logic [CK_W-1:0]             ck_alloc_id,
  input  logic                        ck_rel_valid,
  input  logic                        ck_rst_valid,
  input  logic [CK_W-1:0]             ck_rst_id,
  input  logic                        flush_valid,
  output logic [CK_W:0]               ck_count
);

  localparam logic [CK_W:0] CNT_FULL = (CK_W+1)'(NCKPT);
  localparam logic [CK_W:0] PTR_ONE  = (CK_W+1)'(1);

  logic [PREG_W-1:0] spec_tbl [NUM_LREG];
  logic [PREG_W-1:0] arch_tbl [NUM_LREG];
  logic [PREG_W-1:0] ckpt_tbl [NCKPT][NUM_LREG];

  logic [PREG_W-1:0] spec_next [NUM_LREG];
  logic [PREG_W-1:0] arch_next [NUM_LREG];

  // Pointers carry one extra wrap bit so full and empty are distinct.
  logic [CK_W:0] head_reg, tail_reg;
  logic [CK_W:0] head_rel, cnt_rel;
  logic [CK_W-1:0] rst_off;
  logic rel_ok, rst_ok, alloc_fire;

  logic [3*NPORT*PREG_W-1:0] lookup_flat;

  // Speculative map with this cycle's rename writes; later ports override.
  always_comb begin
    for (int i = 0; i < NUM_LREG; i++) begin
      spec_next[i] = spec_tbl[i];
      for (int p = 0; p < NPORT; p++) begin
        if (wr_valid[p] && (wr_lreg[p*LREG_W +: LREG_W] == LREG_W'(i)))
          spec_next[i] = wr_preg[p*PREG_W +: PREG_W];
      end
    end
  end

  // Architectural map with this cycle's commits; later ports override.
  always_comb begin
    for (int i = 0; i < NUM_LREG; i++) begin
      arch_next[i] = arch_tbl[i];
      for (int p = 0; p < NPORT; p++) begin
        if (cm_valid[p] && (cm_lreg[p*LREG_W +: LREG_W] == LREG_W'(i)))
          arch_next[i] = cm_preg[p*PREG_W +: PREG_W];
      end
    end
  end

  // Checkpoint FIFO control. A release in the same cycle as a restore is
  // applied first, so liveness of the restore slot is judged against the
  // already-advanced head.
  always_comb begin
    ck_count       = tail_reg - head_reg;
    ck_alloc_ready = (ck_count != CNT_FULL);
    ck_alloc_id    = tail_reg[CK_W-1:0];
    rel_ok         = ck_rel_valid && (ck_count != '0);
    head_rel       = rel_ok ? (head_reg + PTR_ONE) : head_reg;
    cnt_rel        = tail_reg - head_rel;
    rst_off        = ck_rst_id - head_rel[CK_W-1:0];
    rst_ok         = ck_rst_valid && !flush_valid && ({1'b0, rst_off} < cnt_rel);
    alloc_fire     = ck_alloc_valid && ck_alloc_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (flush_valid) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else if (rst_ok) begin
      // Restored slot stays live; everything younger is freed. Building the
      // new tail from head keeps the wrap bit consistent.
      head_reg <= head_rel;
      tail_reg <= head_rel + {1'b0, rst_off} + PTR_ONE;
    end else begin
      head_reg <= head_rel;
      if (alloc_fire)
        tail_reg <= tail_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LREG; i++) begin
        spec_tbl[i] <= PREG_W'(i);
        arch_tbl[i] <= PREG_W'(i);
      end
      for (int c = 0; c < NCKPT; c++)
        for (int i = 0; i < NUM_LREG; i++)
          ckpt_tbl[c][i] <= PREG_W'(i);
    end else begin
      for (int i = 0; i < NUM_LREG; i++)
        arch_tbl[i] <= arch_next[i];
      if (flush_valid) begin
        for (int i = 0; i < NUM_LREG; i++)
          spec_tbl[i] <= arch_next[i];
      end else if (rst_ok) begin
        for (int i = 0; i < NUM_LREG; i++)
          spec_tbl[i] <= ckpt_tbl[ck_rst_id][i];
      end else begin
        for (int i = 0; i < NUM_LREG; i++)
          spec_tbl[i] <= spec_next[i];
        if (alloc_fire)
          for (int i = 0; i < NUM_LREG; i++)
            ckpt_tbl[tail_reg[CK_W-1:0]][i] <= spec_next[i];
      end
    end
  end

  // One lookup per {port, field}; field index = gi % 3, port = gi / 3.
  genvar gi;
  generate
    for (gi = 0; gi < 3*NPORT; gi++) begin : g_lookup
      logic [LREG_W-1:0] la;
      logic [PREG_W-1:0] val;
      assign la = rd_lreg[gi*LREG_W +: LREG_W];
`ifdef RAT_CKPT_BYPASS_EN
      localparam int PORT = gi / 3;
      always_comb begin
        val = spec_tbl[la];
        // Only older ports in the group forward into this port's lookups.
        for (int p = 0; p < PORT; p++) begin
          if (wr_valid[p] && (wr_lreg[p*LREG_W +: LREG_W] == la))
            val = wr_preg[p*PREG_W +: PREG_W];
        end
        if (la == '0)
          val = '0;
      end
`else
      always_comb begin
        val = spec_tbl[la];
        if (la == '0)
          val = '0;
      end
`endif
      assign lookup_flat[gi*PREG_W +: PREG_W] = val;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rd_preg <= '0;
    else
      rd_preg <= lookup_flat;
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt (default parameters). Expected values are
// hand-derived constants; the bypass case picks its expectation from
// RAT_CKPT_BYPASS_EN.
module tb_rat_ckpt;

  localparam int NUM_LREG = 32;
  localparam int PREG_W   = 6;
  localparam int NPORT    = 2;
  localparam int NCKPT    = 4;
  localparam int LREG_W   = 5;
  localparam int CK_W     = 2;

  localparam int F_LRS1 = 0;
  localparam int F_LRS2 = 1;
  localparam int F_LRD  = 2;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic [3*NPORT*LREG_W-1:0]   rd_lreg = '0;
  logic [3*NPORT*PREG_W-1:0]   rd_preg;
  logic [NPORT-1:0]            wr_valid = '0;
  logic [NPORT*LREG_W-1:0]     wr_lreg = '0;
  logic [NPORT*PREG_W-1:0]     wr_preg = '0;
  logic [NPORT-1:0]            cm_valid = '0;
  logic [NPORT*LREG_W-1:0]     cm_lreg = '0;
  logic [NPORT*PREG_W-1:0]     cm_preg = '0;
  logic                        ck_alloc_valid = 1'b0;
  logic                        ck_alloc_ready;
  logic [CK_W-1:0]             ck_alloc_id;
  logic                        ck_rel_valid = 1'b0;
  logic                        ck_rst_valid = 1'b0;
  logic [CK_W-1:0]             ck_rst_id = '0;
  logic                        flush_valid = 1'b0;
  logic [CK_W:0]               ck_count;

  int checks = 0;
  int errors = 0;

  rat_ckpt #(
    .NUM_LREG(NUM_LREG), .PREG_W(PREG_W), .NPORT(NPORT), .NCKPT(NCKPT)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_lreg(rd_lreg), .rd_preg(rd_preg),
    .wr_valid(wr_valid), .wr_lreg(wr_lreg), .wr_preg(wr_preg),
    .cm_valid(cm_valid), .cm_lreg(cm_lreg), .cm_preg(cm_preg),
    .ck_alloc_valid(ck_alloc_valid), .ck_alloc_ready(ck_alloc_ready),
    .ck_alloc_id(ck_alloc_id), .ck_rel_valid(ck_rel_valid),
    .ck_rst_valid(ck_rst_valid), .ck_rst_id(ck_rst_id),
    .flush_valid(flush_valid), .ck_count(ck_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_valid = '0; cm_valid = '0; ck_alloc_valid = 1'b0;
    ck_rel_valid = 1'b0; ck_rst_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic set_rd(input int port, input int field, input int lreg);
    rd_lreg[(3*port+field)*LREG_W +: LREG_W] = LREG_W'(lreg);
  endtask

  function automatic int get_rd(input int port, input int field);
    return int'(rd_preg[(3*port+field)*PREG_W +: PREG_W]);
  endfunction

  task automatic set_wr(input int port, input int lreg, input int preg);
    wr_valid[port] = 1'b1;
    wr_lreg[port*LREG_W +: LREG_W] = LREG_W'(lreg);
    wr_preg[port*PREG_W +: PREG_W] = PREG_W'(preg);
  endtask

  task automatic set_cm(input int port, input int lreg, input int preg);
    cm_valid[port] = 1'b1;
    cm_lreg[port*LREG_W +: LREG_W] = LREG_W'(lreg);
    cm_preg[port*PREG_W +: PREG_W] = PREG_W'(preg);
  endtask

  // Present one lookup on port 0 lrs1 and return the registered result.
  task automatic lookup(input int lreg, output int res);
    set_rd(0, F_LRS1, lreg);
    step();
    res = get_rd(0, F_LRS1);
  endtask

  int r;
  int exp_byp;

  initial begin
    // Reset state
    step(); step();
    check("rst_ck_count", int'(ck_count), 0);
    check("rst_alloc_ready", int'(ck_alloc_ready), 1);
    check("rst_alloc_id", int'(ck_alloc_id), 0);
    check("rst_rd_preg", (rd_preg == '0) ? 1 : 0, 1);
    reset = 1'b0;
    step();

    // Identity map and r0 forced to zero
    set_rd(0, F_LRS1, 5); set_rd(1, F_LRD, 31);
    step();
    check("lookup_lrs1_5", get_rd(0, F_LRS1), 5);
    check("lookup_p1_lrd_31", get_rd(1, F_LRD), 31);
    rd_lreg = '0;
    set_wr(0, 0, 20);
    step();
    idle();
    lookup(0, r); check("lookup_r0_zero", r, 0);

    // Same-cycle writes to one lreg: higher port wins
    set_wr(0, 3, 40); set_wr(1, 3, 41);
    step();
    idle();
    lookup(3, r); check("wr_port_priority", r, 41);

    // Checkpoint then restore
    set_wr(0, 7, 50);
    step();
    idle();
    check("alloc_id_first", int'(ck_alloc_id), 0);
    ck_alloc_valid = 1'b1;
    step();
    idle();
    check("count_after_alloc", int'(ck_count), 1);
    set_wr(0, 7, 51);
    step();
    idle();
    lookup(7, r); check("spec_before_restore", r, 51);
    ck_rst_valid = 1'b1; ck_rst_id = 2'd0;
    step();
    idle();
    lookup(7, r); check("restore_value", r, 50);
    check("restore_count", int'(ck_count), 1);
    // Restoring a slot that is not live must be ignored
    ck_rst_valid = 1'b1; ck_rst_id = 2'd2;
    step();
    idle();
    lookup(7, r); check("restore_dead_ignored", r, 50);
    check("restore_dead_count", int'(ck_count), 1);

    // Fill the FIFO from empty
    flush_valid = 1'b1;
    step();
    idle();
    check("flush_count", int'(ck_count), 0);
    ck_alloc_valid = 1'b1;
    repeat (4) step();
    check("full_count", int'(ck_count), 4);
    check("full_ready", int'(ck_alloc_ready), 0);
    step();  // fifth allocation attempt
    idle();
    check("fifth_ignored_count", int'(ck_count), 4);
    check("fifth_ignored_id", int'(ck_alloc_id), 0);
    ck_rel_valid = 1'b1;
    step();
    idle();
    check("release_count", int'(ck_count), 3);
    check("release_ready", int'(ck_alloc_ready), 1);

    // Commit / speculative write / flush
    set_cm(0, 9, 60);
    step();
    idle();
    set_wr(0, 9, 61);
    step();
    idle();
    lookup(9, r); check("spec_before_flush", r, 61);
    flush_valid = 1'b1;
    set_cm(1, 10, 62);  // commit in the flush cycle is included
    step();
    idle();
    lookup(9, r); check("flush_value", r, 60);
    lookup(10, r); check("flush_same_cycle_commit", r, 62);
    check("flush_count_zero", int'(ck_count), 0);
    ck_rel_valid = 1'b1;  // release on empty FIFO is ignored
    step();
    idle();
    check("release_empty_ignored", int'(ck_count), 0);

    // Intra-group forwarding
`ifdef RAT_CKPT_BYPASS_EN
    exp_byp = 33;
`else
    exp_byp = 4;
`endif
    rd_lreg = '0;
    set_wr(0, 4, 33);
    set_rd(1, F_LRS1, 4);
    set_rd(0, F_LRS2, 4);
    step();
    idle();
    check("bypass_p1_lrs1", get_rd(1, F_LRS1), exp_byp);
    check("no_bypass_own_port", get_rd(0, F_LRS2), 4);
    rd_lreg = '0;
    lookup(4, r); check("write_landed_4", r, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
